level_rom: RTL and testbench

- Tile-map ROM holding the wall/floor layout of up to 8 rooms on a 640x480 screen, built from 32x32-pixel tiles (20 columns x 15 rows).
- Answers "is pixel (DrawX, DrawY) a wall in the current room?"
- Used combinationally by Enemy and player collision logic, and by the background renderer.
- Room select is registered; the pixel lookup is combinational.

---
 rtl/level_rom_pkg.sv | 50 +++++
 rtl/level_rom_if.sv | 13 +
 rtl/level_rom.sv | 54 +++++
 tb/tb_level_rom.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/level_rom_pkg.sv
// Shared constants, map types and the fixed room layouts for the level ROM.
// Every room is built from one common border, then its doorways and blocks are applied.
package level_pkg;

  localparam int NUM_ROOMS  = 8;
  localparam int TILE_SHIFT = 5;
  localparam int MAP_COLS   = 20;
  localparam int MAP_ROWS   = 15;
  localparam int COORD_W    = 10;
  localparam int ROOM_W     = 3;
  localparam int COL_W      = 5;
  localparam int ROW_W      = 4;

  typedef logic [19:0]         row_mask_t;
  typedef row_mask_t [0:14]    room_map_t;

  // Bit c of a row mask is column c; 1 = wall.
  localparam row_mask_t FULL_ROW = 20'hF_FFFF;
  localparam row_mask_t SIDE_ROW = 20'h8_0001;

  function automatic room_map_t build_room(input int idx);
    room_map_t m;
    m     = {MAP_ROWS{SIDE_ROW}};
    m[0]  = FULL_ROW;
    m[14] = FULL_ROW;
    if (idx == 0) begin
      m[14][10:9] = 2'b00;
    end else if (idx == 1) begin
      m[0][10:9] = 2'b00;
      m[6][11:8] = 4'hF;
      m[7][11:8] = 4'hF;
      m[8][11:8] = 4'hF;
    end else begin
      // West and east doorways on rows 6-8.
      m[6][0]  = 1'b0;
      m[7][0]  = 1'b0;
      m[8][0]  = 1'b0;
      m[6][19] = 1'b0;
      m[7][19] = 1'b0;
      m[8][19] = 1'b0;
    end
    return m;
  endfunction

  localparam room_map_t ROOM_MAPS [0:7] = '{
    build_room(0), build_room(1), build_room(2), build_room(3),
    build_room(4), build_room(5), build_room(6), build_room(7)
  };

endpackage

// File: rtl/level_rom_if.sv
// Pixel-probe bus of the level ROM: coordinates and room in, wall flag out.
// No valid/ready: inputs are sampled continuously and bg_type always reflects the latest probe.
interface level_rom_if;
  import level_pkg::*;

  logic [COORD_W-1:0] DrawX;
  logic [COORD_W-1:0] DrawY;
  logic [ROOM_W-1:0]  room;
  logic               bg_type;

  modport master (output DrawX, output DrawY, output room, input bg_type);
  modport slave  (input DrawX, input DrawY, input room, output bg_type);
endinterface

// File: rtl/level_rom.sv
// Tile-map wall lookup: registered room select, combinational pixel-to-tile decode.
// Define LEVEL_ROM_REG_OUT_EN to register bg_type for the pixel pipeline.
module level_rom
  import level_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset,
  level_rom_if.slave  bus
);

  logic [ROOM_W-1:0]  r_room_q;
  logic [COORD_W-1:0] w_col_full;
  logic [COORD_W-1:0] w_row_full;
  logic               w_off_screen;
  logic               w_bad_room;
  row_mask_t          w_row_mask;
  logic               w_wall;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) r_room_q <= '0;
    else        r_room_q <= bus.room;
  end

  // Only meaningful when the room field can encode indices beyond the table.
  if (NUM_ROOMS < (1 << ROOM_W)) begin : g_room_chk
    assign w_bad_room = (r_room_q >= ROOM_W'(NUM_ROOMS));
  end else begin : g_room_all
    assign w_bad_room = 1'b0;
  end

  always_comb begin
    w_col_full   = bus.DrawX >> TILE_SHIFT;
    w_row_full   = bus.DrawY >> TILE_SHIFT;
    w_off_screen = (w_col_full >= COORD_W'(MAP_COLS)) ||
                   (w_row_full >= COORD_W'(MAP_ROWS));
    w_row_mask   = ROOM_MAPS[r_room_q][w_row_full[ROW_W-1:0]];
    // Off-screen and unknown rooms read as solid regardless of the mask bit.
    w_wall       = w_off_screen | w_bad_room | w_row_mask[w_col_full[COL_W-1:0]];
  end

`ifdef LEVEL_ROM_REG_OUT_EN
  logic r_bg_type;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) r_bg_type <= 1'b0;
    else        r_bg_type <= w_wall;
  end

  assign bus.bg_type = r_bg_type;
`else
  assign bus.bg_type = w_wall;
`endif

endmodule

// File: tb/tb_level_rom.sv
// Self-checking bench for level_rom: directed vector table, hand sequences, random probes vs. a tile model.
module tb_level_rom;

  logic Clk;
  logic Reset;
  int   n_checks;
  int   n_errors;

  level_rom_if bus();

  level_rom dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  // Clock / reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    int   room;
    int   x;
    int   y;
    logic exp;
    string name;
  } vec_t;

  vec_t vecs [0:15];

  // Reference: room layout evaluated directly from pixel coordinates.
  function automatic logic model_wall(input int room, input int x, input int y);
    int col;
    int row;
    col = x / 32;
    row = y / 32;
    if (col >= 20 || row >= 15 || room >= 8) return 1'b1;
    if (room == 1 && row >= 6 && row <= 8 && col >= 8 && col <= 11) return 1'b1;
    if (room == 0 && row == 14 && (col == 9 || col == 10)) return 1'b0;
    if (room == 1 && row == 0 && (col == 9 || col == 10)) return 1'b0;
    if (room >= 2 && (col == 0 || col == 19) && row >= 6 && row <= 8) return 1'b0;
    return (row == 0 || row == 14 || col == 0 || col == 19);
  endfunction

  task automatic check(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: bg_type=%b expected=%b at t=%0t", name, act, exp, $time);
    end
  endtask

  // Drivers
  task automatic set_room(input int room);
    bus.room = 3'(room);
    @(posedge Clk);
    #1;
  endtask

  // Apply a pixel and wait until its answer is observable.
  task automatic probe(input int x, input int y);
    bus.DrawX = 10'(x);
    bus.DrawY = 10'(y);
`ifdef LEVEL_ROM_REG_OUT_EN
    @(posedge Clk);
    #1;
`else
    #1;
`endif
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    Reset     = 1'b0;
    bus.room  = 3'd1;
    bus.DrawX = 10'd320;
    bus.DrawY = 10'd224;

    vecs[0]  = '{0,   0,   0, 1'b1, "r0_corner"};
    vecs[1]  = '{0,  32,  32, 1'b0, "r0_floor"};
    vecs[2]  = '{0,  31, 100, 1'b1, "r0_x31_col0"};
    vecs[3]  = '{0,  32, 100, 1'b0, "r0_x32_col1"};
    vecs[4]  = '{0, 320, 470, 1'b0, "r0_door_c10"};
    vecs[5]  = '{0, 352, 470, 1'b1, "r0_c11_wall"};
    vecs[6]  = '{0, 288, 460, 1'b0, "r0_door_c9"};
    vecs[7]  = '{2,   5, 224, 1'b0, "r2_west_door"};
    vecs[8]  = '{2,   5, 160, 1'b1, "r2_west_row5"};
    vecs[9]  = '{2, 630, 256, 1'b0, "r2_east_door"};
    vecs[10] = '{3, 700, 600, 1'b1, "offscreen_xy"};
    vecs[11] = '{5, 639, 479, 1'b1, "last_pixel"};
    vecs[12] = '{1, 640, 100, 1'b1, "x640"};
    vecs[13] = '{1, 320,  16, 1'b0, "r1_north_door"};
    vecs[14] = '{1, 288, 224, 1'b1, "r1_block"};
    vecs[15] = '{7,   0, 224, 1'b0, "r7_west_door"};

    // Lookup runs during reset with room 0.
    #12;
    check("reset_r0_floor", bus.bg_type, 1'b0);
    Reset = 1'b1;
    #2;
`ifdef LEVEL_ROM_REG_OUT_EN
    @(posedge Clk); #1;
    @(posedge Clk); #1;
`else
    @(posedge Clk); #1;
`endif
    check("release_r1_block", bus.bg_type, 1'b1);

    foreach (vecs[i]) begin
      set_room(vecs[i].room);
      probe(vecs[i].x, vecs[i].y);
      check(vecs[i].name, bus.bg_type, vecs[i].exp);
    end

`ifdef LEVEL_ROM_REG_OUT_EN
    // Registered output: column change takes one cycle, reset clears at once.
    set_room(0);
    probe(32, 96);
    check("reg_col1_floor", bus.bg_type, 1'b0);
    bus.DrawX = 10'd31;
    #1;
    check("reg_hold_before_edge", bus.bg_type, 1'b0);
    @(posedge Clk); #1;
    check("reg_col0_wall", bus.bg_type, 1'b1);
    #2;
    Reset = 1'b0;
    #1;
    check("reg_async_clear", bus.bg_type, 1'b0);
    #3;
    Reset = 1'b1;
`else
    // Room change shows one cycle later; reset reverts immediately.
    set_room(0);
    probe(320, 16);
    bus.room = 3'd1;
    #1;
    check("room_chg_cycle_n", bus.bg_type, 1'b1);
    @(posedge Clk); #1;
    check("room_chg_cycle_n1", bus.bg_type, 1'b0);
    #2;
    Reset = 1'b0;
    #1;
    check("async_reset_room0", bus.bg_type, 1'b1);
    #3;
    Reset = 1'b1;
`endif

    // Random probes, biased toward the visible area.
    for (int k = 0; k < 300; k++) begin
      int r;
      int x;
      int y;
      r = $urandom_range(0, 7);
      x = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 1023) : $urandom_range(0, 660);
      y = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 1023) : $urandom_range(0, 500);
      set_room(r);
      probe(x, y);
      check($sformatf("rand_r%0d_x%0d_y%0d", r, x, y), bus.bg_type, model_wall(r, x, y));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
